// File: rtl/bus_rr_arbiter.sv
// Round-robin owner of the shared bus: pops one pending transmit FIFO and delivers its packet to the addressed receiver(s).
// Latency: pndng sampled at edge k -> pop in cycle k+1 -> push/d_push in cycle k+2; at most one packet per 3 cycles.
// Backpressure: receivers cannot stall the bus; pops are issued only to non-empty FIFOs, and bad destinations are dropped with err_drop.
module bus_rr_arbiter #(
    parameter int              pckg_sz   = 16,
    parameter int              drvrs     = 4,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
    localparam int             gid_w     = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   d_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         d_push,
    output logic [gid_w-1:0]           grant_id,
    output logic                       busy,
    output logic                       err_drop
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        XFER
    } state_t;

    state_t             state;
    logic [gid_w-1:0]   last_ptr;

    logic               win_vld;
    logic [gid_w-1:0]   win_idx;
    logic [gid_w-1:0]   cand_idx;
    logic [drvrs-1:0]   win_onehot;

    logic [pckg_sz-1:0] head_dat;
    logic [id_w-1:0]    head_dest;
    logic [drvrs-1:0]   xfer_push;
    logic               xfer_drop;

    // Round-robin search starting just after the last winner; walking offsets
    // downward lets the nearest pending driver overwrite farther candidates.
    always_comb begin
        win_vld    = 1'b0;
        win_idx    = '0;
        cand_idx   = '0;
        win_onehot = '0;
        for (int off = drvrs; off >= 1; off--) begin
            cand_idx = gid_w'((int'(last_ptr) + off) % drvrs);
            if (pndng[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
        for (int i = 0; i < drvrs; i++) begin
            win_onehot[i] = win_vld && (win_idx == gid_w'(i));
        end
    end

    // Head-of-FIFO word of the granted driver, read while pop is asserted.
    always_comb begin
        head_dat = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (grant_id == gid_w'(i)) begin
                head_dat = d_pop[i*pckg_sz +: pckg_sz];
            end
        end
    end

    assign head_dest = head_dat[pckg_sz-1 -: id_w];

    // Destination decode: broadcast skips the source, self or out-of-range is dropped.
    always_comb begin
        xfer_push = '0;
        xfer_drop = 1'b0;
        if (head_dest == broadcast) begin
            for (int i = 0; i < drvrs; i++) begin
                xfer_push[i] = (grant_id != gid_w'(i));
            end
        end else if ((int'(head_dest) < drvrs) && (int'(head_dest) != int'(grant_id))) begin
            for (int i = 0; i < drvrs; i++) begin
                xfer_push[i] = (int'(head_dest) == i);
            end
        end else begin
            xfer_drop = 1'b1;
        end
    end

    // Transfer sequencer: grant in IDLE, one-cycle pop, one-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_ptr <= gid_w'(drvrs - 1);
            pop      <= '0;
            push     <= '0;
            d_push   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant_id <= win_idx;
                        pop      <= win_onehot;
                        last_ptr <= win_idx;
                        busy     <= 1'b1;
                        state    <= POP;
                    end
                end
                POP: begin
                    pop      <= '0;
                    push     <= xfer_push;
                    err_drop <= xfer_drop;
                    d_push   <= head_dat;
                    state    <= XFER;
                end
                XFER: begin
                    push     <= '0;
                    err_drop <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shared-bus controller for the emulated bus.
- Polls the drvrs per-driver transmit FIFOs and grants the single bus round-robin to one pending driver.
- Pops that driver's head packet and pushes it to the addressed receiver FIFO(s).
- Destination IDs are 8 bits. The ID field sits in the MSBs of each pckg_sz-bit packet.

Parameters:
- pckg_sz, 16, packet width in bits (bus data width).
- drvrs, 4, number of drivers/receivers on the bus.
- id_w, 8, width of the destination field, packet bits [pckg_sz-1 : pckg_sz-id_w].
- broadcast, 8'hFF, destination value meaning "all drivers except the source".

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pndng, input, drvrs, bit i high = driver i's transmit FIFO is non-empty.
- d_pop, input, drvrs*pckg_sz, head-of-FIFO data; driver i occupies bits [i*pckg_sz +: pckg_sz].
- pop, output, drvrs, one-hot pop strobe to the granted transmit FIFO.
- push, output, drvrs, push strobes to receiver FIFOs.
- d_push, output, pckg_sz, shared bus data, valid while any push bit is high.
- grant_id, output, $clog2(drvrs), index of the current or last granted driver.
- busy, output, 1, high while a transfer is in progress (states POP and XFER).
- err_drop, output, 1, one-cycle pulse when a popped packet is discarded.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - pop=0, push=0, d_push=0, grant_id=0, busy=0, err_drop=0.
  - state=IDLE; last-winner pointer=drvrs-1, so driver 0 has highest priority first.
- All outputs are registered.
- FSM states: IDLE, POP, XFER.
- IDLE:
  - If pndng==0, stay in IDLE.
  - Otherwise winner g = first i with pndng[i]=1, searching from (last+1) mod drvrs upward with wrap.
  - At the edge: grant_id<=g, pop<=onehot(g), last<=g, busy<=1, state<=POP.
- POP (pop high for exactly 1 cycle):
  - At the edge: latch pkt=d_pop[g], pop<=0, state<=XFER.
  - d_pop[g] is sampled while pop is high; the FIFO presents its pre-pop head.
  - pndng is not rechecked; a pop is never withdrawn once issued.
- XFER, with dest = pkt[pckg_sz-1 -: id_w]:
  - dest==broadcast: push = all ones except bit g.
  - dest<drvrs and dest!=g: push = onehot(dest).
  - dest>=drvrs (and not broadcast) or dest==g: push=0, err_drop=1.
  - d_push<=pkt in every case, held until the next transfer overwrites it.
  - These outputs are driven for 1 cycle. At the next edge: push<=0, err_drop<=0, busy<=0, state<=IDLE.
- Latency: pndng sampled at edge k → pop high in cycle k+1 → push high in cycle k+2.
  - One packet per 3 cycles maximum.
  - Arbitration resumes at the edge that ends XFER (IDLE evaluated the following cycle).
- Fairness:
  - With all drivers continuously pending, grants cycle 0,1,2,3,0,...
  - A driver waits at most drvrs-1 transfers.
- Simultaneous events:
  - New pndng bits rising during POP/XFER are ignored until IDLE.
  - The winner is selected only in IDLE.
- Reset mid-operation: the transfer is aborted, push is not issued, and all outputs clear immediately (asynchronously).
- grant_id holds its value outside transfers.
- At most one pop bit is ever high. pop and push are never high in the same cycle.

Test Plan:
- Reset: drive rst_n=0 mid-XFER → push, pop, busy, err_drop are 0 immediately; after release, the first grant with pndng=4'b1111 goes to driver 0.
- Unicast: pndng=4'b0100, d_pop[2]=16'h01AB → pop=4'b0100 one cycle later; next cycle push=4'b0010, d_push=16'h01AB, then busy=0.
- Broadcast: pndng=4'b0001, d_pop[0]=16'hFF55 → push=4'b1110, d_push=16'hFF55 for exactly one cycle.
- Round-robin: pndng held at 4'b1111 for 8 transfers → grant_id sequence 0,1,2,3,0,1,2,3; pop strobes spaced 3 cycles apart.
- Drops: d_pop[1]=16'h0700 (dest 7, out of range), then d_pop[3]=16'h0300 (self) → push=0 and one err_drop pulse each; the pop still occurs each time.
- Late requester: pndng=4'b0010 granted; pndng[0] rises during POP → driver 0 is granted in the IDLE cycle following XFER, not earlier.
